// File: rtl/switch_event_pkg.sv
// Shared definitions for the switch event block: event codes presented
// to the application and the width of the switch index field.
package switch_event_pkg;

   localparam int SW_IDX_W = 3;

   typedef enum logic [1:0] {
      EV_NONE    = 2'b00,
      EV_PRESS   = 2'b01,
      EV_RELEASE = 2'b10,
      EV_LONG    = 2'b11
   } event_e;

endpackage

// File: rtl/switch_event_track.sv
// Per-switch tracker: detects press/release edges, times long presses and
// keeps one pending bit per event type until the arbiter grants it.
// LONG_PRESS_TICKS is expected to be at least 2.
module switch_event_track
   import switch_event_pkg::*;
#(
   parameter int LONG_PRESS_TICKS = 12500000,
   parameter int CNT_W            = 24
) (
   input  logic i_Clk,
   input  logic i_Rst_L,
   input  logic i_Switch,
   input  logic i_Clr_Press,
   input  logic i_Clr_Long,
   input  logic i_Clr_Release,
   output logic o_Pend_Press,
   output logic o_Pend_Long,
   output logic o_Pend_Release,
   output logic o_Overrun
);

   // Counter value that, once reached by an increment, marks a long press.
   localparam logic [CNT_W-1:0] FIRE_AT = CNT_W'(LONG_PRESS_TICKS - 1);

   logic             prev_q, prev_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             long_fired_q, long_fired_d;
   logic             pend_press_q, pend_press_d;
   logic             pend_long_q, pend_long_d;
   logic             pend_release_q, pend_release_d;
   logic             overrun_q, overrun_d;
   logic             rise, fall, set_long;
   logic [CNT_W-1:0] cnt_inc;

   assign rise    = i_Switch & ~prev_q;
   assign fall    = ~i_Switch & prev_q;
   assign cnt_inc = cnt_q + 1'b1;

   // Edge detect and long-press timing; a fired long press freezes the counter.
   always_comb begin
      prev_d       = i_Switch;
      cnt_d        = cnt_q;
      long_fired_d = long_fired_q;
      set_long     = 1'b0;
      if (rise || fall) begin
         cnt_d        = '0;
         long_fired_d = 1'b0;
      end else if (i_Switch && !long_fired_q) begin
         cnt_d = cnt_inc;
         if (cnt_inc == FIRE_AT) begin
            set_long     = 1'b1;
            long_fired_d = 1'b1;
         end
      end
   end

   // Pending bits: a grant in the same cycle as a new event leaves the bit set,
   // while a duplicate onto an ungranted set bit is dropped and flagged.
   always_comb begin
      pend_press_d   = (pend_press_q & ~i_Clr_Press) | rise;
      pend_long_d    = (pend_long_q & ~i_Clr_Long) | set_long;
      pend_release_d = (pend_release_q & ~i_Clr_Release) | fall;
      overrun_d      = overrun_q
                     | (rise & pend_press_q & ~i_Clr_Press)
                     | (set_long & pend_long_q & ~i_Clr_Long)
                     | (fall & pend_release_q & ~i_Clr_Release);
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge i_Clk) begin
      if (!i_Rst_L) begin
         prev_q         <= 1'b0;
         cnt_q          <= '0;
         long_fired_q   <= 1'b0;
         pend_press_q   <= 1'b0;
         pend_long_q    <= 1'b0;
         pend_release_q <= 1'b0;
         overrun_q      <= 1'b0;
      end else begin
         prev_q         <= prev_d;
         cnt_q          <= cnt_d;
         long_fired_q   <= long_fired_d;
         pend_press_q   <= pend_press_d;
         pend_long_q    <= pend_long_d;
         pend_release_q <= pend_release_d;
         overrun_q      <= overrun_d;
      end
   end

   assign o_Pend_Press   = pend_press_q;
   assign o_Pend_Long    = pend_long_q;
   assign o_Pend_Release = pend_release_q;
   assign o_Overrun      = overrun_q;

endmodule

// File: rtl/switch_event_arbiter.sv
// Merges per-switch events into one valid/ready stream using a round-robin
// arbiter over switches with anything pending and a registered output stage.
module switch_event_arbiter
   import switch_event_pkg::*;
#(
   parameter int NUM_SW           = 4,
   parameter int LONG_PRESS_TICKS = 12500000,
   parameter int CNT_W            = 24
) (
   input  logic              i_Clk,
   input  logic              i_Rst_L,
   input  logic [NUM_SW-1:0] i_Switch,
   input  logic              i_Ready,
   output logic              o_Valid,
   output logic [2:0]        o_Sw_Idx,
   output logic [1:0]        o_Event,
   output logic [NUM_SW-1:0] o_Overrun
);

   logic [NUM_SW-1:0]   pend_press, pend_long, pend_release, any_pend;
   logic [NUM_SW-1:0]   clr_press, clr_long, clr_release;
   logic                load_en, found;
   logic [SW_IDX_W-1:0] grant_idx;
   event_e              grant_ev;
   logic [SW_IDX_W-1:0] ptr_q, ptr_d;
   logic [SW_IDX_W-1:0] idx_q, idx_d;
   event_e              ev_q, ev_d;
   logic                valid_q, valid_d;

   for (genvar g = 0; g < NUM_SW; g++) begin : g_track
      switch_event_track #(
         .LONG_PRESS_TICKS(LONG_PRESS_TICKS),
         .CNT_W           (CNT_W)
      ) u_track (
         .i_Clk         (i_Clk),
         .i_Rst_L       (i_Rst_L),
         .i_Switch      (i_Switch[g]),
         .i_Clr_Press   (clr_press[g]),
         .i_Clr_Long    (clr_long[g]),
         .i_Clr_Release (clr_release[g]),
         .o_Pend_Press  (pend_press[g]),
         .o_Pend_Long   (pend_long[g]),
         .o_Pend_Release(pend_release[g]),
         .o_Overrun     (o_Overrun[g])
      );
   end

   assign any_pend = pend_press | pend_long | pend_release;
   assign load_en  = ~valid_q | i_Ready;

   // Round-robin pick: first pending switch at or above the pointer, else wrap to the lowest.
   always_comb begin
      found     = 1'b0;
      grant_idx = '0;
      for (int i = 0; i < NUM_SW; i++) begin
         if (!found && any_pend[i] && (i >= int'(ptr_q))) begin
            found     = 1'b1;
            grant_idx = SW_IDX_W'(i);
         end
      end
      for (int i = 0; i < NUM_SW; i++) begin
         if (!found && any_pend[i]) begin
            found     = 1'b1;
            grant_idx = SW_IDX_W'(i);
         end
      end
   end

   // Event type for the granted switch (press > long > release) and its single clear strobe.
   always_comb begin
      grant_ev    = EV_NONE;
      clr_press   = '0;
      clr_long    = '0;
      clr_release = '0;
      for (int i = 0; i < NUM_SW; i++) begin
         if (found && (grant_idx == SW_IDX_W'(i))) begin
            if (pend_press[i]) begin
               grant_ev     = EV_PRESS;
               clr_press[i] = load_en;
            end else if (pend_long[i]) begin
               grant_ev    = EV_LONG;
               clr_long[i] = load_en;
            end else if (pend_release[i]) begin
               grant_ev       = EV_RELEASE;
               clr_release[i] = load_en;
            end
         end
      end
   end

   // Output register loads when empty or consumed; the pointer advances past each grant.
   always_comb begin
      valid_d = valid_q;
      idx_d   = idx_q;
      ev_d    = ev_q;
      ptr_d   = ptr_q;
      if (load_en) begin
         valid_d = found;
         idx_d   = grant_idx;
         ev_d    = grant_ev;
         if (found) begin
            if (int'(grant_idx) == NUM_SW - 1) begin
               ptr_d = '0;
            end else begin
               ptr_d = grant_idx + 1'b1;
            end
         end
      end
   end

   // Output and pointer registers with synchronous active-low reset.
   always_ff @(posedge i_Clk) begin
      if (!i_Rst_L) begin
         valid_q <= 1'b0;
         idx_q   <= '0;
         ev_q    <= EV_NONE;
         ptr_q   <= '0;
      end else begin
         valid_q <= valid_d;
         idx_q   <= idx_d;
         ev_q    <= ev_d;
         ptr_q   <= ptr_d;
      end
   end

   assign o_Valid  = valid_q;
   assign o_Sw_Idx = idx_q;
   assign o_Event  = ev_q;

endmodule
